fir_stream_ctrl: RTL and testbench

Stream sequencer for the `fir_filter` datapath. It sits between a valid/ready sample source and sink and drives the filter's `clk_en` and `data_in`, exposing `data_out` as a back-pressurable output stream. It tracks the delay-line fill, can suppress warm-up outputs, and runs a flush that drains the tail with zero samples and leaves the delay line cleared.

---
 rtl/fir_stream_ctrl.sv | 118 +++++++++++
 tb/tb_fir_stream_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_ctrl.sv
// Valid/ready sequencer for an external FIR datapath: gates the filter clock
// enable, tracks delay-line fill, optionally hides warm-up results and flushes the tail.
module fir_stream_ctrl #(
  parameter int NUM_TABS       = 3,
  parameter int TAB_WIDTH      = 3,
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = TAB_WIDTH + DATA_IN_WIDTH + 8,
  parameter int DROP_FILL      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_OUT_WIDTH-1:0] m_data,
  output logic                      m_last,
  output logic                      fir_clk_en,
  output logic [DATA_IN_WIDTH-1:0]  fir_data_in,
  input  logic [DATA_OUT_WIDTH-1:0] fir_data_out
);

  localparam int FILL_MAX = NUM_TABS - 1;
  localparam int FW       = $clog2(NUM_TABS);
  localparam int ZW       = $clog2(NUM_TABS + 1);

  // DONE is the one-cycle flush_done slot between the last zero and RUN.
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                   state_q, state_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [ZW-1:0]            zc_q, zc_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_last_q, m_last_d;
  logic                     slot, en, visible, last_zero, s_ready_c;
  logic [DATA_IN_WIDTH-1:0] din;

  always_comb begin
    slot      = !m_valid_q || m_ready;
    s_ready_c = 1'b0;
    en        = 1'b0;
    din       = '0;
    visible   = 1'b0;
    last_zero = 1'b0;
    state_d   = state_q;
    fill_d    = fill_q;
    zc_d      = zc_q;
    case (state_q)
      RUN: begin
        s_ready_c = slot;
        if (s_valid && slot) begin
          en      = 1'b1;
          din     = s_data;
          visible = !((DROP_FILL != 0) && (fill_q < FW'(FILL_MAX)));
          if (fill_q != FW'(FILL_MAX)) fill_d = fill_q + 1'b1;
        end
        // An empty delay line has no tail, so go straight to the done pulse.
        if (flush) state_d = (fill_d == '0) ? DONE : FLUSH;
      end
      FLUSH: begin
        if (slot) begin
          en   = 1'b1;
          zc_d = zc_q + 1'b1;
          if (zc_q == ZW'(FILL_MAX)) begin
            state_d = DONE;
            zc_d    = '0;
            fill_d  = '0;
          end else begin
            visible   = 1'b1;
            last_zero = (zc_q == ZW'(FILL_MAX - 1));
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (en) begin
      m_valid_d = visible;
      m_last_d  = last_zero;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      fill_q    <= '0;
      zc_q      <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      zc_q      <= zc_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  assign s_ready     = s_ready_c && !rst;
  assign fir_clk_en  = en && !rst;
  assign fir_data_in = rst ? '0 : din;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_data      = fir_data_out;
  assign busy        = (state_q == FLUSH);
  assign flush_done  = (state_q == DONE);

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench: two controllers (DROP_FILL 0 and 1) share stimulus, each
// driving a small FIR stand-in; results are checked against a convolution model.
`timescale 1ns/1ps
module tb_fir_stream_ctrl;
  localparam int N   = 3;
  localparam int DOW = 3 + 8 + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           s_valid = 1'b0, flush = 1'b0, m_ready = 1'b1;
  logic [7:0]     s_data = '0;
  logic           s_ready0, flush_done0, busy0, m_valid0, m_last0, en0;
  logic           s_ready1, flush_done1, busy1, m_valid1, m_last1, en1;
  logic [DOW-1:0] m_data0, fo0, m_data1, fo1;
  logic [7:0]     fdi0, fdi1;

  fir_stream_ctrl #(.NUM_TABS(N), .TAB_WIDTH(3), .DATA_IN_WIDTH(8), .DROP_FILL(0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .flush(flush), .flush_done(flush_done0), .busy(busy0), .m_valid(m_valid0),
    .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0), .fir_clk_en(en0),
    .fir_data_in(fdi0), .fir_data_out(fo0));

  fir_stream_ctrl #(.NUM_TABS(N), .TAB_WIDTH(3), .DATA_IN_WIDTH(8), .DROP_FILL(1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .flush(flush), .flush_done(flush_done1), .busy(busy1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .fir_clk_en(en1),
    .fir_data_in(fdi1), .fir_data_out(fo1));

  // Filter stand-in with coefficients 1,2,3 (newest sample first).
  logic [7:0] dl0 [N];
  logic [7:0] dl1 [N];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin dl0[i] <= '0; dl1[i] <= '0; end
    end else begin
      if (en0) begin dl0[0] <= fdi0; for (int i = 1; i < N; i++) dl0[i] <= dl0[i-1]; end
      if (en1) begin dl1[0] <= fdi1; for (int i = 1; i < N; i++) dl1[i] <= dl1[i-1]; end
    end
  end
  assign fo0 = DOW'(dl0[0]) + DOW'(dl0[1]) * DOW'(2) + DOW'(dl0[2]) * DOW'(3);
  assign fo1 = DOW'(dl1[0]) + DOW'(dl1[1]) * DOW'(2) + DOW'(dl1[2]) * DOW'(3);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Observed traffic
  logic [DOW-1:0] g0_d[$];
  logic           g0_l[$];
  int             g0_c[$];
  logic [DOW-1:0] g1_d[$];
  int             g1_c[$];
  logic [7:0]     en_d[$];
  int             en_c[$];
  int             done_c[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid0 && m_ready) begin g0_d.push_back(m_data0); g0_l.push_back(m_last0); g0_c.push_back(cyc); end
      if (m_valid1 && m_ready) begin g1_d.push_back(m_data1); g1_c.push_back(cyc); end
      if (en0) begin en_d.push_back(fdi0); en_c.push_back(cyc); end
      if (flush_done0) done_c.push_back(cyc);
    end
  end

  // Reference model: history of filter inputs since the last clear.
  int             hist[$];
  logic [DOW-1:0] e_d[$];
  logic           e_l[$];
  int             acc_c[$];

  function automatic logic [DOW-1:0] conv();
    int s = 0;
    for (int i = 0; i < N; i++)
      if (hist.size() > i) s += (i + 1) * hist[hist.size() - 1 - i];
    return DOW'(s);
  endfunction

  task automatic model_sample(input logic [7:0] v);
    hist.push_back(int'(v));
    e_d.push_back(conv());
    e_l.push_back(1'b0);
  endtask

  task automatic model_flush();
    if (hist.size() != 0) begin
      for (int k = 1; k < N; k++) begin
        hist.push_back(0);
        e_d.push_back(conv());
        e_l.push_back(k == N - 1);
      end
      hist.delete();
    end
  endtask

  task automatic clear_all();
    g0_d.delete(); g0_l.delete(); g0_c.delete(); g1_d.delete(); g1_c.delete();
    en_d.delete(); en_c.delete(); done_c.delete();
    e_d.delete(); e_l.delete(); acc_c.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    s_valid = 1'b1;
    s_data  = v;
    @(negedge clk);
    while (s_ready0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_accept: s_ready=%b after %0d cycles, required 1", s_ready0, n);
    end else begin
      acc_c.push_back(cyc);
      model_sample(v);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid0, m_last0, flush_done0, busy0, en0, s_ready0} !== 6'b0 || fdi0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut0: v/l/done/busy/en/rdy=%b din=%h, required 000000 00",
               {m_valid0, m_last0, flush_done0, busy0, en0, s_ready0}, fdi0);
    end
    checks++;
    if ({m_valid1, m_last1, flush_done1, busy1, en1, s_ready1} !== 6'b0 || fdi1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut1: v/l/done/busy/en/rdy=%b din=%h, required 000000 00",
               {m_valid1, m_last1, flush_done1, busy1, en1, s_ready1}, fdi1);
    end
    tick();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", s_ready0); end
    tick();
    clear_all(); hist.delete();
  endtask

  task automatic test_flush_empty();
    int tf;
    clear_all();
    flush = 1'b1; tf = cyc; tick(); flush = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_done0 !== 1'b1 || s_ready0 !== 1'b0) begin
      errors++; $display("FAIL flush_empty_t1: done=%b rdy=%b, required 1 0", flush_done0, s_ready0);
    end
    tick();
    @(negedge clk);
    checks++;
    if (flush_done0 !== 1'b0 || s_ready0 !== 1'b1) begin
      errors++; $display("FAIL flush_empty_t2: done=%b rdy=%b, required 0 1", flush_done0, s_ready0);
    end
    repeat (3) tick();
    checks++;
    if (en_c.size() != 0 || g0_d.size() != 0 || done_c.size() != 1 || done_c[0] != tf + 1) begin
      errors++;
      $display("FAIL flush_empty_traffic: en=%0d beats=%0d dones=%0d, required 0 0 1 at t+1",
               en_c.size(), g0_d.size(), done_c.size());
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    send(8'h01); send(8'h01); send(8'h00);
    repeat (3) tick();
    checks++;
    if (en_c.size() != 3 || g0_d.size() != 3 || acc_c[2] - acc_c[0] != 2) begin
      errors++; $display("FAIL b2b_counts: en=%0d beats=%0d span=%0d, required 3 3 2",
                         en_c.size(), g0_d.size(), acc_c[2] - acc_c[0]);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (g0_d[i] !== e_d[i] || g0_c[i] != acc_c[i] + 1) begin
          errors++; $display("FAIL b2b_beat%0d: data=%0d cyc=%0d, required %0d cyc=%0d",
                             i, g0_d[i], g0_c[i], e_d[i], acc_c[i] + 1);
        end
      end
    end
    clear_all();
    for (int i = 0; i < 8; i++) send(8'($urandom));
    repeat (3) tick();
    checks++;
    if (g0_d.size() != 8 || acc_c[7] - acc_c[0] != 7) begin
      errors++; $display("FAIL b2b_rand_count: beats=%0d span=%0d, required 8 7", g0_d.size(), acc_c[7] - acc_c[0]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (g0_d[i] !== e_d[i] || g0_l[i] !== 1'b0) begin
          errors++; $display("FAIL b2b_rand%0d: data=%0d last=%b, required %0d 0", i, g0_d[i], g0_l[i], e_d[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DOW-1:0] held;
    int stall;
    clear_all();
    for (int r = 0; r < 3; r++) begin
      stall = (r == 0) ? 4 : int'($urandom_range(1, 6));
      send(8'($urandom));
      held = e_d[e_d.size() - 1];
      m_ready = 1'b0; s_valid = 1'b1; s_data = 8'($urandom);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        checks++;
        if (m_valid0 !== 1'b1 || m_data0 !== held || s_ready0 !== 1'b0 || en0 !== 1'b0) begin
          errors++; $display("FAIL bp_hold r%0d c%0d: v=%b data=%0d rdy=%b en=%b, required 1 %0d 0 0",
                             r, i, m_valid0, m_data0, s_ready0, en0, held);
        end
        tick();
      end
      m_ready = 1'b1;
      send(s_data);
    end
    repeat (3) tick();
    checks++;
    if (g0_d.size() != e_d.size()) begin
      errors++; $display("FAIL bp_count: beats=%0d, required %0d", g0_d.size(), e_d.size());
    end else begin
      for (int i = 0; i < e_d.size(); i++) begin
        checks++;
        if (g0_d[i] !== e_d[i]) begin
          errors++; $display("FAIL bp_beat%0d: data=%0d, required %0d", i, g0_d[i], e_d[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int tf, nz;
    clear_all();
    for (int i = 0; i < 4; i++) send(8'($urandom));
    repeat (2) tick();
    flush = 1'b1; tf = cyc; model_flush(); tick(); flush = 0;
    for (int i = 1; i <= N + 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_ready0 !== (i >= N + 2) || busy0 !== (i <= N)) begin
        errors++; $display("FAIL flush_t+%0d: rdy=%b busy=%b, required %b %b",
                           i, s_ready0, busy0, i >= N + 2, i <= N);
      end
      tick();
    end
    nz = 0;
    for (int i = 0; i < en_c.size(); i++) if (en_c[i] > tf && en_d[i] == 8'h00) nz++;
    checks++;
    if (nz != N || en_c.size() != 4 + N || done_c.size() != 1 || done_c[0] != tf + N + 1) begin
      errors++; $display("FAIL flush_timing: zero_en=%0d en=%0d dones=%0d, required %0d %0d 1 at t+%0d",
                         nz, en_c.size(), done_c.size(), N, 4 + N, N + 1);
    end
    checks++;
    if (g0_d.size() != 6 || g0_c[5] != tf + N || g0_l[5] !== 1'b1 || g0_l[4] !== 1'b0) begin
      errors++; $display("FAIL flush_tail: beats=%0d, required 6 with m_last only on the final beat", g0_d.size());
    end
    send(8'h01); send(8'h00); send(8'h00);
    repeat (3) tick();
    checks++;
    if (g0_d.size() != 9) begin
      errors++; $display("FAIL flush_count: beats=%0d, required 9", g0_d.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (g0_d[i] !== e_d[i] || g0_l[i] !== e_l[i]) begin
          errors++; $display("FAIL flush_beat%0d: data=%0d last=%b, required %0d %b", i, g0_d[i], g0_l[i], e_d[i], e_l[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (g0_d[6+i] !== DOW'(i + 1)) begin
          errors++; $display("FAIL impulse%0d: data=%0d, required %0d", i, g0_d[6+i], i + 1);
        end
      end
    end
  endtask

  task automatic test_flush_coincident();
    logic [7:0] v;
    clear_all();
    v = 8'($urandom);
    s_valid = 1'b1; s_data = v; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b1) begin errors++; $display("FAIL coinc_ready: got %b, required 1", s_ready0); end
    model_sample(v); model_flush();
    tick(); s_valid = 1'b0; flush = 1'b0;
    repeat (N + 4) tick();
    checks++;
    if (g0_d.size() != N || done_c.size() != 1) begin
      errors++; $display("FAIL coinc_count: beats=%0d dones=%0d, required %0d 1", g0_d.size(), done_c.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (g0_d[i] !== e_d[i] || g0_l[i] !== e_l[i]) begin
          errors++; $display("FAIL coinc_beat%0d: data=%0d last=%b, required %0d %b", i, g0_d[i], g0_l[i], e_d[i], e_l[i]);
        end
      end
    end
  endtask

  task automatic test_drop_fill();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    hist.delete(); clear_all();
    for (int i = 0; i < 5; i++) send(8'($urandom));
    repeat (3) tick();
    checks++;
    if (g1_d.size() != 3 || g0_d.size() != 5) begin
      errors++; $display("FAIL drop_count: dut1 beats=%0d dut0 beats=%0d, required 3 5", g1_d.size(), g0_d.size());
    end else begin
      checks++;
      if (g1_c[0] != acc_c[2] + 1) begin
        errors++; $display("FAIL drop_first_cycle: got %0d, required %0d", g1_c[0], acc_c[2] + 1);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (g1_d[i] !== e_d[i+2]) begin
          errors++; $display("FAIL drop_beat%0d: data=%0d, required %0d", i, g1_d[i], e_d[i+2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_all();
    send(8'($urandom)); send(8'($urandom));
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL midflush_busy: got %b, required 1", busy0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid0, m_last0, flush_done0, busy0, en0, s_ready0} !== 6'b0 || fdi0 !== 8'h00) begin
      errors++; $display("FAIL midflush_reset: v/l/done/busy/en/rdy=%b din=%h, required 000000 00",
                         {m_valid0, m_last0, flush_done0, busy0, en0, s_ready0}, fdi0);
    end
    tick(); tick();
    rst = 1'b0;
    hist.delete(); clear_all();
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("FAIL midflush_release: rdy=%b busy=%b, required 1 0", s_ready0, busy0);
    end
    repeat (N + 4) tick();
    checks++;
    if (done_c.size() != 0 || g0_d.size() != 0 || en_c.size() != 0) begin
      errors++; $display("FAIL midflush_after: dones=%0d beats=%0d en=%0d, required 0 0 0",
                         done_c.size(), g0_d.size(), en_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_flush_empty();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_coincident();
    test_drop_fill();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
